// File: rtl/alu_writeback.sv
// alu_writeback: execute-to-writeback stage with C/Z/N flags and a 2-entry register-write FIFO
module alu_writeback #(
   parameter int WIDTH      = 8,
   parameter int REG_ADDR_W = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_result,
   input  logic                  in_carry,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic                  in_we,
   input  logic                  in_flag_en,
   input  logic                  flush,
   output logic                  wb_valid,
   input  logic                  wb_ready,
   output logic [WIDTH-1:0]      wb_data,
   output logic [REG_ADDR_W-1:0] wb_addr,
   output logic                  flag_c,
   output logic                  flag_z,
   output logic                  flag_n,
   output logic [1:0]            wb_count,
   input  logic [REG_ADDR_W-1:0] lookup_addr,
   output logic                  pend_hit
);
   logic [WIDTH-1:0]      d [2];
   logic [REG_ADDR_W-1:0] a [2];
   logic [1:0]            cnt, cnt_n;
   logic                  rp, wp, rp_n, wp_n, acc, push, pop, head_new;
   assign in_ready = cnt != 2'd2;
   assign wb_valid = cnt != 2'd0;
   assign wb_count = cnt;
   assign pend_hit = (wb_valid && a[rp] == lookup_addr) || (cnt == 2'd2 && a[~rp] == lookup_addr);
   always_comb begin
      acc      = in_valid & in_ready & ~flush;
      push     = acc & in_we;
      pop      = wb_valid & wb_ready & ~flush;
      cnt_n    = flush ? 2'd0 : cnt + 2'(push) - 2'(pop);
      rp_n     = flush ? 1'b0 : rp ^ pop;
      wp_n     = flush ? 1'b0 : wp ^ push;
      head_new = push && wp == rp_n;
   end
   // wb_data/wb_addr preload the next head so they stay registered and hold when empty
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         rp      <= 1'b0;
         wp      <= 1'b0;
         d[0]    <= '0;
         d[1]    <= '0;
         a[0]    <= '0;
         a[1]    <= '0;
         wb_data <= '0;
         wb_addr <= '0;
         flag_c  <= 1'b0;
         flag_z  <= 1'b0;
         flag_n  <= 1'b0;
      end else begin
         cnt <= cnt_n;
         rp  <= rp_n;
         wp  <= wp_n;
         if (push) begin
            d[wp] <= in_result;
            a[wp] <= in_rd;
         end
         if (acc && in_flag_en) begin
            flag_c <= in_carry;
            flag_z <= in_result == '0;
            flag_n <= in_result[WIDTH-1];
         end
         if (cnt_n != 2'd0) begin
            wb_data <= head_new ? in_result : d[rp_n];
            wb_addr <= head_new ? in_rd : a[rp_n];
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (cnt != 2'd3);
         assert (!(push && cnt == 2'd2));
         assert (!(pop && cnt == 2'd0));
      end
   end
endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed and randomized checks against a queue-based reference model
module tb_alu_writeback;
   localparam int W = 8;
   localparam int A = 3;
   logic clk = 0, rst = 1, in_valid = 0, in_carry = 0, in_we = 0, in_flag_en = 0, flush = 0, wb_ready = 0;
   logic [W-1:0] in_result = 0;
   logic [A-1:0] in_rd = 0, lookup_addr = 0;
   logic in_ready, wb_valid, flag_c, flag_z, flag_n, pend_hit;
   logic [W-1:0] wb_data;
   logic [A-1:0] wb_addr;
   logic [1:0] wb_count;
   int checks = 0, failures = 0;
   bit mon_en = 0;
   typedef struct packed {logic [A-1:0] a; logic [W-1:0] d;} ent_t;
   ent_t sb[$];
   logic [W-1:0] hd_d = 0;
   logic [A-1:0] hd_a = 0;
   logic mc = 0, mz = 0, mn = 0;
   bit m_rdy, m_pop, m_hit;

   alu_writeback #(.WIDTH(W), .REG_ADDR_W(A)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
      .in_carry(in_carry), .in_rd(in_rd), .in_we(in_we), .in_flag_en(in_flag_en), .flush(flush),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_addr(wb_addr),
      .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .wb_count(wb_count),
      .lookup_addr(lookup_addr), .pend_hit(pend_hit)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [A-1:0] rd, input logic [W-1:0] res,
                        input logic c, input logic we, input logic fe);
      in_valid = v; in_rd = rd; in_result = res; in_carry = c; in_we = we; in_flag_en = fe;
   endtask

   // Reference model: queue holds the queued writes in order; head/flags follow the rules directly
   always @(posedge clk) begin
      m_rdy = sb.size() != 2;
      m_pop = sb.size() != 0 && wb_ready && !flush;
      if (rst) begin
         sb.delete();
         hd_d = 0; hd_a = 0; mc = 0; mz = 0; mn = 0;
      end else if (flush) begin
         sb.delete();
      end else begin
         if (m_pop) void'(sb.pop_front());
         if (in_valid && m_rdy && in_we) sb.push_back(ent_t'{a: in_rd, d: in_result});
         if (in_valid && m_rdy && in_flag_en) begin
            mc = in_carry;
            mz = in_result == 0;
            mn = in_result >= 8'h80;
         end
         if (sb.size() != 0) begin
            hd_d = sb[0].d;
            hd_a = sb[0].a;
         end
      end
   end

   // Monitor: compares DUT state and every write handshake against the model
   always @(negedge clk) begin
      if (mon_en) begin
         m_hit = 0;
         foreach (sb[i]) if (sb[i].a == lookup_addr) m_hit = 1;
         chk("wb_count", 32'(wb_count), 32'(sb.size()));
         chk("wb_valid", 32'(wb_valid), 32'(sb.size() != 0));
         chk("in_ready", 32'(in_ready), 32'(sb.size() != 2));
         chk("wb_data", 32'(wb_data), 32'(hd_d));
         chk("wb_addr", 32'(wb_addr), 32'(hd_a));
         chk("flags_czn", 32'({flag_c, flag_z, flag_n}), 32'({mc, mz, mn}));
         chk("pend_hit", 32'(pend_hit), 32'(m_hit));
         if (wb_valid && wb_ready && !flush && !rst)
            chk("pop_order", 32'({wb_addr, wb_data}),
                sb.size() != 0 ? 32'({sb[0].a, sb[0].d}) : 32'hxxxxxxxx);
      end
   end

   initial begin
      rst = 1;
      cyc();
      mon_en = 1;
      cyc();
      rst = 0;
      cyc();
      chk("t1_in_ready", 32'(in_ready), 1);
      chk("t1_wb_valid", 32'(wb_valid), 0);
      chk("t1_flags", 32'({flag_c, flag_z, flag_n}), 0);
      chk("t1_count", 32'(wb_count), 0);
      drive(1, 3, 8'h80, 1, 1, 1);
      cyc();
      drive(1, 0, 8'h00, 0, 0, 1);
      chk("t2_wb_valid", 32'(wb_valid), 1);
      chk("t2_wb_addr", 32'(wb_addr), 3);
      chk("t2_wb_data", 32'(wb_data), 32'h80);
      chk("t2_flags", 32'({flag_c, flag_z, flag_n}), 32'b101);
      cyc();
      drive(0, 0, 0, 0, 0, 0);
      chk("t2_flags_zero", 32'({flag_c, flag_z, flag_n}), 32'b010);
      chk("t2_count", 32'(wb_count), 1);
      wb_ready = 1;
      cyc();
      wb_ready = 0;
      chk("t2_drained", 32'(wb_count), 0);
      drive(1, 1, 8'h11, 0, 1, 0);
      cyc();
      drive(1, 2, 8'h22, 0, 1, 0);
      cyc();
      chk("t3_count", 32'(wb_count), 2);
      chk("t3_in_ready", 32'(in_ready), 0);
      drive(1, 4, 8'h44, 0, 1, 0);
      cyc();
      chk("t3_held_off", 32'(wb_count), 2);
      drive(0, 0, 0, 0, 0, 0);
      lookup_addr = 2;
      #1 chk("t3_hit2", 32'(pend_hit), 1);
      lookup_addr = 5;
      #1 chk("t3_hit5", 32'(pend_hit), 0);
      wb_ready = 1;
      chk("t3_head1", 32'(wb_addr), 1);
      cyc();
      chk("t3_head2", 32'(wb_addr), 2);
      chk("t3_data2", 32'(wb_data), 32'h22);
      cyc();
      chk("t3_empty", 32'(wb_valid), 0);
      chk("t3_hold", 32'(wb_addr), 2);
      wb_ready = 0;
      drive(1, 6, 8'h66, 0, 1, 0);
      cyc();
      chk("t4_count1", 32'(wb_count), 1);
      drive(1, 7, 8'h77, 0, 1, 0);
      wb_ready = 1;
      cyc();
      chk("t4_count_stay", 32'(wb_count), 1);
      chk("t4_new_head", 32'({wb_addr, wb_data}), 32'({3'd7, 8'h77}));
      for (int i = 0; i < 20; i++) begin
         drive(1, 3'(i), 8'($urandom), 0, 1, 0);
         cyc();
         chk("t4_b2b_count", 32'(wb_count), 1);
      end
      drive(0, 0, 0, 0, 0, 0);
      cyc();
      wb_ready = 0;
      cyc();
      chk("t4_drained", 32'(wb_count), 0);
      drive(1, 1, 8'h81, 1, 1, 1);
      cyc();
      drive(1, 2, 8'h42, 0, 1, 0);
      cyc();
      chk("t5_flags_pre", 32'({flag_c, flag_z, flag_n}), 32'b101);
      drive(1, 5, 8'h00, 0, 1, 1);
      flush = 1;
      cyc();
      flush = 0;
      drive(0, 0, 0, 0, 0, 0);
      lookup_addr = 1;
      #1;
      chk("t5_count", 32'(wb_count), 0);
      chk("t5_wb_valid", 32'(wb_valid), 0);
      chk("t5_flags", 32'({flag_c, flag_z, flag_n}), 32'b101);
      chk("t5_pend_hit", 32'(pend_hit), 0);
      drive(1, 3, 8'h10, 0, 1, 0);
      cyc();
      drive(1, 5, 8'h00, 0, 1, 1);
      flush = 1;
      cyc();
      flush = 0;
      drive(0, 0, 0, 0, 0, 0);
      chk("t5b_count", 32'(wb_count), 0);
      chk("t5b_flags", 32'({flag_c, flag_z, flag_n}), 32'b101);
      drive(1, 4, 8'h55, 0, 1, 0);
      cyc();
      drive(1, 6, 8'h66, 0, 1, 0);
      cyc();
      drive(0, 0, 0, 0, 0, 0);
      chk("t1b_count_pre", 32'(wb_count), 2);
      rst = 1;
      cyc();
      rst = 0;
      chk("t1b_in_ready", 32'(in_ready), 1);
      chk("t1b_wb_valid", 32'(wb_valid), 0);
      chk("t1b_flags", 32'({flag_c, flag_z, flag_n}), 0);
      chk("t1b_count", 32'(wb_count), 0);
      chk("t1b_wb_data", 32'({wb_addr, wb_data}), 0);
      for (int i = 0; i < 3000; i++) begin
         drive(1'($urandom_range(0, 1)), 3'($urandom), $urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom),
               1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom));
         wb_ready = 1'($urandom_range(0, 2) != 0);
         flush = $urandom_range(0, 31) == 0;
         rst = $urandom_range(0, 499) == 0;
         lookup_addr = 3'($urandom);
         cyc();
      end
      drive(0, 0, 0, 0, 0, 0);
      flush = 0;
      rst = 0;
      wb_ready = 1;
      repeat (3) cyc();
      chk("final_empty", 32'(wb_count), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
